// File: rtl/cmos_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cmos_capture_ctrl
// Description : Pixel-clock-side frame capture controller. Gates capture start,
//               discards sensor settle frames, aligns on vsync, packs byte
//               pairs into 16-bit pixels, gates FIFO writes and reports
//               per-frame status (counters, sticky overflow / size error).
// Revision    : 1.0 - initial release
// ============================================================================
module cmos_capture_ctrl #(
    parameter int SKIP_FRAMES = 10,
    parameter int H_PIXELS    = 640,
    parameter int V_LINES     = 480,
    parameter bit VS_POL      = 1'b1
) (
    input  logic        cmos_pclk,
    input  logic        rst,
    input  logic        capture_en,
    input  logic        clear_err,
    input  logic        cmos_href_delay,
    input  logic        cmos_vsync_delay,
    input  logic [7:0]  cmos_data_delay,
    input  logic        fifo_full,
    output logic [15:0] pixel_data,
    output logic        pixel_valid,
    output logic        frame_start,
    output logic        frame_done,
    output logic [11:0] x_cnt,
    output logic [11:0] y_cnt,
    output logic [15:0] frame_cnt,
    output logic        overflow,
    output logic        size_err,
    output logic        busy
);

    localparam bit          c_HAS_SKIP  = (SKIP_FRAMES > 0);
    localparam logic [15:0] c_SKIP_LAST = 16'(SKIP_FRAMES);
    localparam logic [11:0] c_H         = 12'(H_PIXELS);
    localparam logic [11:0] c_V         = 12'(V_LINES);
    localparam logic [11:0] c_CNT_MAX   = 12'hFFF;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SKIP    = 2'd1,
        S_VBLANK  = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_enter_cap;
    logic        w_frame_end;

    logic        r_href;
    logic        r_vsync;
    logic [15:0] r_skip_cnt;
    logic        r_phase;
    logic [7:0]  r_hi_byte;
    logic [15:0] r_pixel_data;
    logic        r_pixel_valid;
    logic        r_frame_start;
    logic        r_frame_done;
    logic [11:0] r_x_cnt;
    logic [11:0] r_y_cnt;
    logic [15:0] r_frame_cnt;
    logic        r_overflow;
    logic        r_size_err;

    logic        w_vs_act;
    logic        w_vs_act_q;
    logic        w_vs_end;
    logic        w_vs_begin;
    logic        w_href_fall;
    logic        w_in_cap;
    logic        w_pix_form;
    logic        w_line_has;
    logic        w_ovf_set;
    logic        w_serr_set;

    assign w_vs_act    = (cmos_vsync_delay == VS_POL);
    assign w_vs_act_q  = (r_vsync == VS_POL);
    assign w_vs_end    = w_vs_act_q & ~w_vs_act;
    assign w_vs_begin  = ~w_vs_act_q & w_vs_act;
    assign w_href_fall = r_href & ~cmos_href_delay;
    assign w_in_cap    = (r_state == S_CAPTURE);
    // A pixel is formed on the second byte of a pair while the line is active.
    assign w_pix_form  = w_in_cap & cmos_href_delay & r_phase;
    // x_cnt saturates non-zero, so this tells whether the line carried any byte.
    assign w_line_has  = (r_x_cnt != 12'd0) | r_phase;
    assign w_ovf_set   = w_pix_form & fifo_full;
    assign w_serr_set  = (w_in_cap & w_href_fall & ((r_x_cnt != c_H) | r_phase))
                       | (w_frame_end & (r_y_cnt != c_V));

    // Edge-detect copies of href/vsync; reset also loads the live inputs.
    always_ff @(posedge cmos_pclk) begin
        r_href  <= cmos_href_delay;
        r_vsync <= cmos_vsync_delay;
    end

    // FSM state register.
    always_ff @(posedge cmos_pclk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM next-state and frame boundary strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_enter_cap = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (capture_en) w_state_nxt = c_HAS_SKIP ? S_SKIP : S_VBLANK;
            end
            S_SKIP: begin
                if (!capture_en) begin
                    w_state_nxt = S_IDLE;
                end else if (w_vs_end && (r_skip_cnt == c_SKIP_LAST)) begin
                    w_state_nxt = S_CAPTURE;
                    w_enter_cap = 1'b1;
                end
            end
            S_VBLANK: begin
                if (w_vs_end) begin
                    if (capture_en) begin
                        w_state_nxt = S_CAPTURE;
                        w_enter_cap = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_CAPTURE: begin
                // capture_en is deliberately ignored here: the frame always finishes.
                if (w_vs_begin) begin
                    w_state_nxt = S_VBLANK;
                    w_frame_end = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Settle-frame counter, restarted every time the FSM passes through IDLE.
    always_ff @(posedge cmos_pclk) begin
        if (rst || (r_state == S_IDLE)) r_skip_cnt <= 16'd0;
        else if ((r_state == S_SKIP) && w_vs_end) r_skip_cnt <= r_skip_cnt + 16'd1;
    end

    // Byte packing, FIFO write strobe, line/frame counters and frame pulses.
    always_ff @(posedge cmos_pclk) begin
        if (rst) begin
            r_phase       <= 1'b0;
            r_hi_byte     <= 8'd0;
            r_pixel_data  <= 16'd0;
            r_pixel_valid <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_x_cnt       <= 12'd0;
            r_y_cnt       <= 12'd0;
            r_frame_cnt   <= 16'd0;
        end else begin
            r_pixel_valid <= 1'b0;
            r_frame_start <= w_enter_cap;
            r_frame_done  <= w_frame_end;
            if (w_enter_cap) begin
                r_phase <= 1'b0;
                r_x_cnt <= 12'd0;
                r_y_cnt <= 12'd0;
            end else if (w_in_cap) begin
                if (w_href_fall) begin
                    // Any trailing odd byte is simply discarded here.
                    r_phase <= 1'b0;
                    r_x_cnt <= 12'd0;
                    if (w_line_has && (r_y_cnt != c_CNT_MAX)) r_y_cnt <= r_y_cnt + 12'd1;
                end else if (cmos_href_delay) begin
                    if (!r_phase) begin
                        r_hi_byte <= cmos_data_delay;
                        r_phase   <= 1'b1;
                    end else begin
                        r_phase <= 1'b0;
                        // Dropped pixels still count so line length checks stay exact.
                        if (r_x_cnt != c_CNT_MAX) r_x_cnt <= r_x_cnt + 12'd1;
                        if (!fifo_full) begin
                            r_pixel_valid <= 1'b1;
                            r_pixel_data  <= {r_hi_byte, cmos_data_delay};
                        end
                    end
                end
            end
            if (w_frame_end) r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    // Sticky error flags; a set event in the same cycle as clear_err wins.
    always_ff @(posedge cmos_pclk) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_size_err <= 1'b0;
        end else begin
            if (w_ovf_set)      r_overflow <= 1'b1;
            else if (clear_err) r_overflow <= 1'b0;
            if (w_serr_set)     r_size_err <= 1'b1;
            else if (clear_err) r_size_err <= 1'b0;
        end
    end

    assign pixel_data  = r_pixel_data;
    assign pixel_valid = r_pixel_valid;
    assign frame_start = r_frame_start;
    assign frame_done  = r_frame_done;
    assign x_cnt       = r_x_cnt;
    assign y_cnt       = r_y_cnt;
    assign frame_cnt   = r_frame_cnt;
    assign overflow    = r_overflow;
    assign size_err    = r_size_err;
    assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cmos_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmos_capture_ctrl
// Description : Scoreboard bench for cmos_capture_ctrl. Two instances share
//               the stimulus: A (SKIP_FRAMES=2, active-high vsync) and
//               B (SKIP_FRAMES=0, active-low vsync driven with inverted vsync).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmos_capture_ctrl;

    localparam int H = 4;
    localparam int V = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, capture_en, clear_err, href, vs, vs_n, fifo_full;
    logic [7:0] data;
    assign vs_n = ~vs;

    logic [1:0][15:0] pd;
    logic [1:0]       pv, fs, fd, ovf, serr, bsy;
    logic [1:0][11:0] xc, yc;
    logic [1:0][15:0] fc;

    cmos_capture_ctrl #(.SKIP_FRAMES(2), .H_PIXELS(H), .V_LINES(V), .VS_POL(1'b1)) u_dut_a (
        .cmos_pclk(clk), .rst(rst), .capture_en(capture_en), .clear_err(clear_err),
        .cmos_href_delay(href), .cmos_vsync_delay(vs), .cmos_data_delay(data),
        .fifo_full(fifo_full), .pixel_data(pd[0]), .pixel_valid(pv[0]),
        .frame_start(fs[0]), .frame_done(fd[0]), .x_cnt(xc[0]), .y_cnt(yc[0]),
        .frame_cnt(fc[0]), .overflow(ovf[0]), .size_err(serr[0]), .busy(bsy[0]));

    cmos_capture_ctrl #(.SKIP_FRAMES(0), .H_PIXELS(H), .V_LINES(V), .VS_POL(1'b0)) u_dut_b (
        .cmos_pclk(clk), .rst(rst), .capture_en(capture_en), .clear_err(clear_err),
        .cmos_href_delay(href), .cmos_vsync_delay(vs_n), .cmos_data_delay(data),
        .fifo_full(fifo_full), .pixel_data(pd[1]), .pixel_valid(pv[1]),
        .frame_start(fs[1]), .frame_done(fd[1]), .x_cnt(xc[1]), .y_cnt(yc[1]),
        .frame_cnt(fc[1]), .overflow(ovf[1]), .size_err(serr[1]), .busy(bsy[1]));

    // Scoreboard queues: pixel = {data16, x_cnt12}; done = {frame_cnt16, y_cnt12, size_err1}
    logic [27:0] q_pix[2][$];
    logic [28:0] q_done[2][$];
    int fs_exp[2];
    int fs_act[2];
    int n_checks = 0;
    int n_err    = 0;
    bit mon_en   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input int l, input int i);
        return 8'((l << 4) + i + 1);
    endfunction

    // Monitor: pops and compares whenever a DUT presents pixel/frame events.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                logic [27:0] ep;
                logic [28:0] ed;
                if (pv[d] === 1'b1) begin
                    if (q_pix[d].size() == 0) begin
                        n_checks++; n_err++;
                        $display("FAIL unexpected_pixel dut%0d: got data %0h expected none", d, pd[d]);
                    end else begin
                        ep = q_pix[d].pop_front();
                        chk($sformatf("pix_data dut%0d", d), 32'(pd[d]), 32'(ep[27:12]));
                        chk($sformatf("pix_xcnt dut%0d", d), 32'(xc[d]), 32'(ep[11:0]));
                    end
                end
                if (fd[d] === 1'b1) begin
                    if (q_done[d].size() == 0) begin
                        n_checks++; n_err++;
                        $display("FAIL unexpected_done dut%0d: got frame_cnt %0h expected none", d, fc[d]);
                    end else begin
                        ed = q_done[d].pop_front();
                        chk($sformatf("done_fcnt dut%0d", d), 32'(fc[d]), 32'(ed[28:13]));
                        chk($sformatf("done_ycnt dut%0d", d), 32'(yc[d]), 32'(ed[12:1]));
                        chk($sformatf("done_serr dut%0d", d), 32'(serr[d]), 32'(ed[0]));
                    end
                end
                if (fs[d] === 1'b1) begin
                    fs_act[d]++;
                    chk($sformatf("start_xy dut%0d", d), {xc[d], yc[d]}, 32'd0);
                end
            end
        end
    end

    task automatic drv(input logic h, input logic v, input logic [7:0] d);
        href = h; vs = v; data = d;
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_pv dut%0d", tag, d), 32'(pv[d]), 32'd0);
            chk($sformatf("%s_pd dut%0d", tag, d), 32'(pd[d]), 32'd0);
            chk($sformatf("%s_fsfd dut%0d", tag, d), {fs[d], fd[d]}, 32'd0);
            chk($sformatf("%s_xy dut%0d", tag, d), {xc[d], yc[d]}, 32'd0);
            chk($sformatf("%s_fcnt dut%0d", tag, d), 32'(fc[d]), 32'd0);
            chk($sformatf("%s_flags dut%0d", tag, d), {ovf[d], serr[d]}, 32'd0);
            chk($sformatf("%s_busy dut%0d", tag, d), 32'(bsy[d]), 32'd0);
        end
    endtask

    // One vsync period followed by nl lines; cap[d] says whether DUT d captures it.
    task automatic frame(input int nl, input int odd_line, input int odd_len,
                         input int full_pix, input bit clr_start, input bit clr_full,
                         input bit drop_en, input bit chk_idle, input bit [1:0] cap,
                         input logic [15:0] fca, input logic [15:0] fcb, input bit serr_exp);
        int nb;
        for (int d = 0; d < 2; d++) begin
            if (cap[d]) begin
                fs_exp[d]++;
                q_done[d].push_back({(d == 0) ? fca : fcb, 12'(nl), serr_exp});
                for (int l = 0; l < nl; l++) begin
                    nb = (l == odd_line) ? odd_len : 2 * H;
                    for (int p = 0; p < nb / 2; p++)
                        if (!(l == 0 && p == full_pix))
                            q_pix[d].push_back({byte_of(l, 2 * p), byte_of(l, 2 * p + 1), 12'(p + 1)});
                end
            end
        end
        drv(0, 1, 0);
        if (clr_start) begin
            clear_err = 1'b1; drv(0, 1, 0);
            clear_err = 1'b0; drv(0, 1, 0);
            for (int d = 0; d < 2; d++)
                chk($sformatf("clear_flags dut%0d", d), {ovf[d], serr[d]}, 32'd0);
        end else begin
            drv(0, 1, 0); drv(0, 1, 0);
        end
        drv(0, 0, 0); drv(0, 0, 0);
        if (chk_idle)
            for (int d = 0; d < 2; d++) chk($sformatf("idle_busy dut%0d", d), 32'(bsy[d]), 32'd0);
        for (int l = 0; l < nl; l++) begin
            nb = (l == odd_line) ? odd_len : 2 * H;
            for (int i = 0; i < nb; i++) begin
                fifo_full = (l == 0 && full_pix >= 0 && (i / 2) == full_pix);
                clear_err = clr_full && l == 0 && i == 2 * full_pix + 1;
                if (drop_en && l == 0 && i == 3) capture_en = 1'b0;
                drv(1, 0, byte_of(l, i));
            end
            fifo_full = 1'b0; clear_err = 1'b0;
            drv(0, 0, 0);
            for (int d = 0; d < 2; d++) begin
                if (l == 0 && full_pix >= 0)
                    chk($sformatf("overflow dut%0d", d), 32'(ovf[d]), 32'(cap[d]));
                if (l == odd_line)
                    chk($sformatf("line_serr dut%0d", d), 32'(serr[d]), 32'(cap[d]));
            end
            drv(0, 0, 0); drv(0, 0, 0);
        end
    endtask

    initial begin
        rst = 1'b1; capture_en = 1'b0; clear_err = 1'b0; href = 1'b0; vs = 1'b1;
        fifo_full = 1'b0; data = 8'd0;
        fs_exp = '{0, 0}; fs_act = '{0, 0};
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        mon_en = 1'b1;
        rst = 1'b0; capture_en = 1'b1;
        drv(0, 1, 0);
        for (int d = 0; d < 2; d++) chk($sformatf("en_busy dut%0d", d), 32'(bsy[d]), 32'd1);

        //     nl odd len full clrS clrF drop idle cap    fcA fcB serr
        frame(2, -1, 8, -1, 0, 0, 0, 0, 2'b10, 0, 1, 0);
        frame(2, -1, 8, -1, 0, 0, 0, 0, 2'b10, 0, 2, 0);
        frame(2, -1, 8, -1, 0, 0, 0, 0, 2'b11, 1, 3, 0);
        frame(2, -1, 8,  2, 0, 0, 0, 0, 2'b11, 2, 4, 0);   // dropped 3rd pixel
        frame(2,  1, 7,  0, 1, 1, 0, 0, 2'b11, 3, 5, 1);   // odd line, set beats clear
        frame(3, -1, 8, -1, 1, 0, 0, 0, 2'b11, 4, 6, 1);   // too many lines
        frame(2,  0, 9, -1, 1, 0, 1, 0, 2'b11, 5, 7, 1);   // odd line x=H, capture_en drop
        frame(2, -1, 8, -1, 0, 0, 0, 1, 2'b00, 0, 0, 0);   // back to IDLE

        // Reset mid-line while capture_en stays high.
        capture_en = 1'b1;
        fs_exp[1]++;
        q_pix[1].push_back({16'h0102, 12'd1});
        drv(0, 1, 0); drv(0, 1, 0); drv(0, 1, 0);
        drv(0, 0, 0); drv(0, 0, 0);
        drv(1, 0, 8'h01); drv(1, 0, 8'h02); drv(1, 0, 8'h03);
        rst = 1'b1;
        drv(1, 0, 8'h04);
        rst = 1'b0;
        chk_all_zero("midrst");
        for (int i = 5; i <= 8; i++) drv(1, 0, 8'(i));
        drv(0, 0, 0); drv(0, 0, 0);
        for (int d = 0; d < 2; d++) chk($sformatf("rst_busy dut%0d", d), 32'(bsy[d]), 32'd1);

        frame(2, -1, 8, -1, 0, 0, 0, 0, 2'b10, 0, 1, 0);
        frame(2, -1, 8, -1, 0, 0, 0, 0, 2'b10, 0, 2, 0);
        frame(2, -1, 8, -1, 0, 0, 0, 0, 2'b11, 1, 3, 0);
        drv(0, 1, 0); drv(0, 1, 0); drv(0, 1, 0); drv(0, 1, 0);

        for (int d = 0; d < 2; d++) begin
            chk($sformatf("pix_left dut%0d", d), 32'(q_pix[d].size()), 32'd0);
            chk($sformatf("done_left dut%0d", d), 32'(q_done[d].size()), 32'd0);
            chk($sformatf("start_count dut%0d", d), 32'(fs_act[d]), 32'(fs_exp[d]));
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
